wb_arbiter: RTL and testbench

Write-back arbiter between the two execution-side producers and the reorder buffer. The ALU and the store/load buffer (SLB) can each finish one instruction per cycle, but the ROB completion port takes one result per cycle. This block buffers each producer's results in a small FIFO, arbitrates between the FIFO heads, and drives one registered completion beat per cycle toward the ROB. On a ROB exception it discards all in-flight results.

---
 rtl/wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_wb_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-source FIFOs for ALU and SLB results feeding one registered ROB completion beat.
// Optional macro WB_RR_EN selects round-robin between both valid heads; default is fixed ALU priority.
module wb_arbiter #(
  parameter int unsigned DataLength = 31,
  parameter int unsigned DepthLog   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                alu_valid,
  input  logic [DataLength:0] alu_data,
  input  logic [DataLength:0] alu_pc,
  input  logic [DataLength:0] alu_jpc,
  output logic                alu_ready,
  input  logic                slb_valid,
  input  logic [DataLength:0] slb_data,
  input  logic [DataLength:0] slb_pc,
  output logic                slb_ready,
  output logic                out_valid,
  output logic                out_is_alu,
  output logic [DataLength:0] out_data,
  output logic [DataLength:0] out_pc,
  output logic [DataLength:0] out_jpc
);

  localparam int unsigned DW    = DataLength + 1;
  localparam int unsigned D     = 1 << DepthLog;
  localparam int unsigned CNT_W = DepthLog + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [DW-1:0] pc;
    logic [DW-1:0] jpc;
  } alu_ent_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [DW-1:0] pc;
  } slb_ent_t;

  alu_ent_t alu_mem [D];
  slb_ent_t slb_mem [D];

  logic [DepthLog-1:0] alu_rptr, alu_wptr, slb_rptr, slb_wptr;
  logic [CNT_W-1:0]    alu_cnt, slb_cnt;
  logic                last_grant;

  logic alu_push, slb_push;
  logic alu_nonempty, slb_nonempty;
  logic prefer_slb;
  logic grant_alu, grant_slb;
  logic alu_pop, slb_pop;

  // Ready looks only at the registered count; a same-cycle pop does not reopen it.
  assign alu_ready = rdy && (alu_cnt < CNT_W'(D));
  assign slb_ready = rdy && (slb_cnt < CNT_W'(D));

  assign alu_push = alu_valid && alu_ready && !flush;
  assign slb_push = slb_valid && slb_ready && !flush;

  assign alu_nonempty = (alu_cnt != '0);
  assign slb_nonempty = (slb_cnt != '0);

`ifdef WB_RR_EN
  assign prefer_slb = ~last_grant;
`else
  // Fixed priority: last_grant is tracked but never consulted.
  assign prefer_slb = last_grant & 1'b0;
`endif

  // Head arbitration on registered empty flags; new pushes are never bypassed.
  always_comb begin
    grant_alu = 1'b0;
    grant_slb = 1'b0;
    if (alu_nonempty && slb_nonempty) begin
      grant_slb = prefer_slb;
      grant_alu = ~prefer_slb;
    end else if (alu_nonempty) begin
      grant_alu = 1'b1;
    end else if (slb_nonempty) begin
      grant_slb = 1'b1;
    end
  end

  assign alu_pop = rdy && !flush && grant_alu;
  assign slb_pop = rdy && !flush && grant_slb;

  // Payload storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (rdy && alu_push) alu_mem[alu_wptr] <= '{data: alu_data, pc: alu_pc, jpc: alu_jpc};
    if (rdy && slb_push) slb_mem[slb_wptr] <= '{data: slb_data, pc: slb_pc};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_rptr   <= '0;
      alu_wptr   <= '0;
      slb_rptr   <= '0;
      slb_wptr   <= '0;
      alu_cnt    <= '0;
      slb_cnt    <= '0;
      last_grant <= 1'b0;
      out_valid  <= 1'b0;
      out_is_alu <= 1'b0;
      out_data   <= '0;
      out_pc     <= '0;
      out_jpc    <= '0;
    end else if (rdy) begin
      if (flush) begin
        alu_rptr   <= '0;
        alu_wptr   <= '0;
        slb_rptr   <= '0;
        slb_wptr   <= '0;
        alu_cnt    <= '0;
        slb_cnt    <= '0;
        last_grant <= 1'b0;
        out_valid  <= 1'b0;
      end else begin
        if (alu_push) alu_wptr <= alu_wptr + DepthLog'(1);
        if (alu_pop)  alu_rptr <= alu_rptr + DepthLog'(1);
        if (slb_push) slb_wptr <= slb_wptr + DepthLog'(1);
        if (slb_pop)  slb_rptr <= slb_rptr + DepthLog'(1);

        if (alu_push && !alu_pop)      alu_cnt <= alu_cnt + CNT_W'(1);
        else if (!alu_push && alu_pop) alu_cnt <= alu_cnt - CNT_W'(1);
        if (slb_push && !slb_pop)      slb_cnt <= slb_cnt + CNT_W'(1);
        else if (!slb_push && slb_pop) slb_cnt <= slb_cnt - CNT_W'(1);

        out_valid <= alu_pop || slb_pop;
        if (alu_pop) begin
          out_is_alu <= 1'b1;
          out_data   <= alu_mem[alu_rptr].data;
          out_pc     <= alu_mem[alu_rptr].pc;
          out_jpc    <= alu_mem[alu_rptr].jpc;
          last_grant <= 1'b0;
        end else if (slb_pop) begin
          out_is_alu <= 1'b0;
          out_data   <= slb_mem[slb_rptr].data;
          out_pc     <= slb_mem[slb_rptr].pc;
          out_jpc    <= slb_mem[slb_rptr].pc + DW'(4);
          last_grant <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-level reference model predicts each completion beat,
// a negedge monitor pops and compares. Honours WB_RR_EN the same way the design does.
module tb_wb_arbiter;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        alu_valid = 1'b0;
  logic [31:0] alu_data = '0, alu_pc = '0, alu_jpc = '0;
  logic        alu_ready;
  logic        slb_valid = 1'b0;
  logic [31:0] slb_data = '0, slb_pc = '0;
  logic        slb_ready;
  logic        out_valid, out_is_alu;
  logic [31:0] out_data, out_pc, out_jpc;

  wb_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alu_valid(alu_valid), .alu_data(alu_data), .alu_pc(alu_pc), .alu_jpc(alu_jpc),
    .alu_ready(alu_ready),
    .slb_valid(slb_valid), .slb_data(slb_data), .slb_pc(slb_pc), .slb_ready(slb_ready),
    .out_valid(out_valid), .out_is_alu(out_is_alu),
    .out_data(out_data), .out_pc(out_pc), .out_jpc(out_jpc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_alu;
    logic [31:0] data;
    logic [31:0] pc;
    logic [31:0] jpc;
  } beat_t;

  beat_t aq[$];
  beat_t sq[$];
  beat_t exp_q[$];
  beat_t cur;
  logic  exp_valid = 1'b0;
`ifdef WB_RR_EN
  logic  m_last = 1'b0;
`endif

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: each source is an ordered queue of at most D results; one beat per cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      aq.delete(); sq.delete(); exp_q.delete();
      exp_valid = 1'b0;
`ifdef WB_RR_EN
      m_last = 1'b0;
`endif
    end else if (rdy) begin
      if (flush) begin
        aq.delete(); sq.delete();
        exp_valid = 1'b0;
`ifdef WB_RR_EN
        m_last = 1'b0;
`endif
      end else begin
        bit a_ok, s_ok, take_alu, take_slb;
        a_ok = aq.size() < D;
        s_ok = sq.size() < D;
        take_alu = 1'b0;
        take_slb = 1'b0;
        if (aq.size() > 0 && sq.size() > 0) begin
`ifdef WB_RR_EN
          take_slb = (m_last == 1'b0);
          take_alu = !take_slb;
`else
          take_alu = 1'b1;
`endif
        end else begin
          take_alu = aq.size() > 0;
          take_slb = sq.size() > 0;
        end
        exp_valid = take_alu || take_slb;
        if (take_alu) begin
          exp_q.push_back(aq.pop_front());
`ifdef WB_RR_EN
          m_last = 1'b0;
`endif
        end else if (take_slb) begin
          exp_q.push_back(sq.pop_front());
`ifdef WB_RR_EN
          m_last = 1'b1;
`endif
        end
        if (alu_valid && a_ok) aq.push_back('{1'b1, alu_data, alu_pc, alu_jpc});
        if (slb_valid && s_ok) sq.push_back('{1'b0, slb_data, slb_pc, slb_pc + 32'd4});
      end
    end
  end

  // Monitor: away from the active edge, compare the presented beat and readies with the model.
  always @(negedge clk) begin
    if (rst) begin
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("alu_ready", 32'(alu_ready), 32'(rdy && aq.size() < D));
      chk("slb_ready", 32'(slb_ready), 32'(rdy && sq.size() < D));
      if (exp_valid && out_valid) begin
        chk("out_is_alu", 32'(out_is_alu), 32'(cur.is_alu));
        chk("out_data", out_data, cur.data);
        chk("out_pc", out_pc, cur.pc);
        chk("out_jpc", out_jpc, cur.jpc);
      end
    end
  end

  task automatic drive(input bit av, input bit sv, input bit fl, input bit r,
                       input logic [31:0] ad, input logic [31:0] ap, input logic [31:0] aj,
                       input logic [31:0] sd, input logic [31:0] sp);
    alu_valid = av; alu_data = ad; alu_pc = ap; alu_jpc = aj;
    slb_valid = sv; slb_data = sd; slb_pc = sp;
    flush = fl; rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1, '0, '0, '0, '0, '0);
  endtask

  task automatic both(input int n, input bit fl, input bit r);
    for (int i = 0; i < n; i++)
      drive(1, 1, fl, r, $urandom, 32'h200 + 32'(i * 4), 32'h204 + 32'(i * 4),
            $urandom, 32'h300 + 32'(i * 4));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_is_alu"}, 32'(out_is_alu), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_pc"}, out_pc, 32'd0);
    chk({tag, "_jpc"}, out_jpc, 32'd0);
    chk({tag, "_alu_ready"}, 32'(alu_ready), 32'(rdy));
    chk({tag, "_slb_ready"}, 32'(slb_ready), 32'(rdy));
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 chk_zero_outputs("reset");
    #9 rst = 1'b1;
    idle(2);

    // Single ALU result travels through in two edges.
    drive(1, 0, 0, 1, 32'h11, 32'h100, 32'h104, '0, '0);
    idle(3);

    // Both sources saturated: arbitration order and SLB back-pressure.
    both(12, 0, 1);
    idle(14);

    // Flush with both FIFOs partly full; pushes in the flush cycle are lost.
    both(5, 0, 1);
    both(1, 1, 1);
    idle(4);

    // Freeze with rdy low, then resume in order.
    both(4, 0, 1);
    both(3, 0, 0);
    idle(12);

    // Randomized traffic with occasional stalls and flushes.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 29) == 0, $urandom_range(0, 9) != 0,
            $urandom, $urandom, $urandom, $urandom, $urandom);
    idle(14);

    // Asynchronous reset mid-stream drops everything without a clock edge.
    both(3, 0, 1);
    #2 rst = 1'b0;
    #1 chk_zero_outputs("async_rst");
    #2;
    alu_valid = 1'b0; slb_valid = 1'b0; flush = 1'b0; rdy = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    both(3, 0, 1);
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
